// File: rtl/ev_cmd_sequencer.sv
// Command sequencer for the EV motor controller: drives controller pins for one
// op, waits SETTLE_CYCLES, then captures status/speed into a response.
// Optional build macro SPEED_CHECK_EN adds a motor-speed plausibility check for op 100.
module ev_cmd_sequencer #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [7:0] cmd_data,
  input  logic       cmd_power,
  output logic [7:0] ctl_ui,
  output logic [7:0] ctl_uio,
  input  logic [7:0] status_in,
  input  logic [7:0] speed_in,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_status,
  output logic [7:0] rsp_speed,
  output logic       rsp_err
);

  // Out-of-range settle values are clamped so the counter load is always 1..255.
  localparam logic [7:0] SETTLE_LD =
    (SETTLE_CYCLES < 1)   ? 8'd1   :
    (SETTLE_CYCLES > 255) ? 8'd255 : 8'(SETTLE_CYCLES);

  typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;

  state_t     state, state_nx;
  logic [7:0] cnt, cnt_nx;
  logic       pwr_q, pwr_nx;
  logic       alive;
  logic [7:0] ui_nx, uio_nx;
  logic       rsp_valid_nx, rsp_err_nx;
  logic [7:0] rsp_status_nx, rsp_speed_nx;
  logic       spd_bad;

  assign cmd_ready = alive && (state == IDLE);

`ifdef SPEED_CHECK_EN
  // Pins still hold the op and accel/brake operands on the capture edge.
  logic [3:0] accel, brake;
  logic [7:0] spd_exp;
  always_comb begin
    accel   = ctl_uio[7:4];
    brake   = ctl_uio[3:0];
    spd_exp = (accel > brake) ? {4'(accel - brake), 4'b0000} : 8'h00;
    spd_bad = (ctl_ui[2:0] == 3'b100) && !status_in[5] && (speed_in != spd_exp);
  end
`else
  assign spd_bad = 1'b0;
`endif

  always_comb begin
    state_nx      = state;
    cnt_nx        = cnt;
    pwr_nx        = pwr_q;
    ui_nx         = ctl_ui;
    uio_nx        = ctl_uio;
    rsp_valid_nx  = rsp_valid;
    rsp_status_nx = rsp_status;
    rsp_speed_nx  = rsp_speed;
    rsp_err_nx    = rsp_err;
    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          pwr_nx      = cmd_power;
          cnt_nx      = SETTLE_LD;
          ui_nx       = 8'h00;
          ui_nx[2:0]  = cmd_op;
          ui_nx[3]    = cmd_power;
          ui_nx[6]    = (cmd_op == 3'b001) && cmd_data[0];
          uio_nx      = 8'h00;
          case (cmd_op)
            3'b010:  uio_nx[0] = cmd_data[0];
            3'b011:  uio_nx[2] = cmd_data[0];
            3'b100:  uio_nx    = cmd_data;
            default: uio_nx    = 8'h00;
          endcase
          state_nx    = DRIVE;
        end
      end
      DRIVE: begin
        if (cnt <= 8'd1) begin
          rsp_status_nx = status_in;
          rsp_speed_nx  = speed_in;
          rsp_err_nx    = (status_in[0] != pwr_q) || spd_bad;
          rsp_valid_nx  = 1'b1;
          ui_nx         = {4'b0000, pwr_q, 3'b000};
          uio_nx        = 8'h00;
          state_nx      = RESP;
        end else begin
          cnt_nx = cnt - 8'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_nx = 1'b0;
          state_nx     = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= 8'h00;
      pwr_q      <= 1'b0;
      alive      <= 1'b0;
      ctl_ui     <= 8'h00;
      ctl_uio    <= 8'h00;
      rsp_valid  <= 1'b0;
      rsp_status <= 8'h00;
      rsp_speed  <= 8'h00;
      rsp_err    <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      pwr_q      <= pwr_nx;
      alive      <= 1'b1;
      ctl_ui     <= ui_nx;
      ctl_uio    <= uio_nx;
      rsp_valid  <= rsp_valid_nx;
      rsp_status <= rsp_status_nx;
      rsp_speed  <= rsp_speed_nx;
      rsp_err    <= rsp_err_nx;
    end
  end

endmodule
